// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that lets one of four requesters at a time stream a
//   burst of up to BURST_MAX words into a downstream synchronous FIFO.
//   Two states: IDLE (arbitrate, one cycle) and BURST (owner streams words).
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   requestValid    [3:0] per-requester word valid
//   requestData     [4*DATA_WIDTH-1:0] requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   requestLast     [3:0] per-requester last-word-of-packet flag
//   requestReady    [3:0] per-requester accept (owner only, gated by !fifoFull)
//   fifoFull        FIFO full flag
//   fifoWriteEnable FIFO write strobe
//   fifoWriteData   FIFO write word (owner's word, combinational)
//   grantActive     high while in BURST
//   grantIndex      current / most recent owner

// Per-requester datapath slice: readiness, handshake and data gating.
// Non-owners drive zeros so the OR-reduction in the top only ever sees the
// owner's word and last flag.
module fifo_write_arbiter_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  own,
    input  logic                  fifoFull,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  last,
    output logic                  ready,
    output logic                  fire,
    output logic [DATA_WIDTH-1:0] dataGated,
    output logic                  lastGated
);
    assign ready     = own & ~fifoFull;
    assign fire      = ready & valid;
    assign dataGated = fire ? data : '0;
    assign lastGated = fire & last;
endmodule

module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              requestValid,
    input  logic [4*DATA_WIDTH-1:0] requestData,
    input  logic [3:0]              requestLast,
    output logic [3:0]              requestReady,
    input  logic                    fifoFull,
    output logic                    fifoWriteEnable,
    output logic [DATA_WIDTH-1:0]   fifoWriteData,
    output logic                    grantActive,
    output logic [1:0]              grantIndex
);
    localparam int NUM_REQ = 4;
    localparam int CW      = $clog2(BURST_MAX);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] burstCount;
    logic [1:0]    lastOwner;

    logic [NUM_REQ-1:0]                 own;
    logic [NUM_REQ-1:0]                 fireVec;
    logic [NUM_REQ-1:0]                 lastVec;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] dataVec;

    logic       pickValid;
    logic [1:0] pickIdx;
    logic [1:0] cand;
    logic       fire;
    logic       endBurst;

    // Ownership is also dropped while reset is high so a reset landing in the
    // middle of a burst suppresses the write in that very cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign own[gi] = (state == ST_BURST) && (grantIndex == 2'(gi)) && !reset;
            fifo_write_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .own       (own[gi]),
                .fifoFull  (fifoFull),
                .valid     (requestValid[gi]),
                .data      (requestData[gi*DATA_WIDTH +: DATA_WIDTH]),
                .last      (requestLast[gi]),
                .ready     (requestReady[gi]),
                .fire      (fireVec[gi]),
                .dataGated (dataVec[gi]),
                .lastGated (lastVec[gi])
            );
        end
    endgenerate

    always_comb begin
        fifoWriteData = '0;
        for (int i = 0; i < NUM_REQ; i++) fifoWriteData = fifoWriteData | dataVec[i];
    end

    assign fire            = |fireVec;
    assign fifoWriteEnable = fire;
    assign endBurst        = (|lastVec) || (burstCount == CW'(BURST_MAX - 1));
    assign grantActive     = (state == ST_BURST);

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = lastOwner;
        cand      = lastOwner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = lastOwner + 2'(k);
            if (!pickValid && requestValid[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            burstCount <= '0;
            lastOwner  <= 2'd3;
            grantIndex <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pickValid) begin
                        state      <= ST_BURST;
                        grantIndex <= pickIdx;
                        burstCount <= '0;
                    end
                end
                default: begin
                    if (fire) begin
                        if (endBurst) begin
                            state      <= ST_IDLE;
                            lastOwner  <= grantIndex;
                            burstCount <= '0;
                        end else begin
                            burstCount <= burstCount + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
    localparam int DW = 8;
    localparam int BM = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    requestValid;
    logic [4*DW-1:0] requestData;
    logic [3:0]    requestLast;
    logic [3:0]    requestReady;
    logic          fifoFull;
    logic          fifoWriteEnable;
    logic [DW-1:0] fifoWriteData;
    logic          grantActive;
    logic [1:0]    grantIndex;

    int errors = 0;
    int checks = 0;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .clock           (clock),
        .reset           (reset),
        .requestValid    (requestValid),
        .requestData     (requestData),
        .requestLast     (requestLast),
        .requestReady    (requestReady),
        .fifoFull        (fifoFull),
        .fifoWriteEnable (fifoWriteEnable),
        .fifoWriteData   (fifoWriteData),
        .grantActive     (grantActive),
        .grantIndex      (grantIndex)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        f;
        logic [3:0]  rdy;
        logic        we;
        logic [7:0]  wd;
        logic        ga;
        logic [1:0]  gi;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rst, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f, input logic [3:0] rdy,
                       input logic we, input logic [7:0] wd, input logic ga, input logic [1:0] gi);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.f = f;
        r.rdy = rdy; r.we = we; r.wd = wd; r.ga = ga; r.gi = gi;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; requestValid = '0; requestData = '0; requestLast = '0; fifoFull = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [5:0] seq [4];
    logic       endExp;
    int         bw;
    int         writes;
    logic [7:0] expWord;

    initial begin
        reset = 1'b1; requestValid = '0; requestData = '0; requestLast = '0; fifoFull = 1'b0;
        repeat (2) @(posedge clock);

        // reset state
        row(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        // requester 2 alone, 3 words, Last on the third; non-owner Last noise ignored
        row(0, 4'b0100, 32'h55A16677, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        row(0, 4'b0100, 32'h55A16677, 4'b1011, 0, 4'b0100, 1, 8'hA1, 1, 2'd2);
        row(0, 4'b0100, 32'h55A26677, 4'b0000, 0, 4'b0100, 1, 8'hA2, 1, 2'd2);
        row(0, 4'b0100, 32'h55A36677, 4'b0100, 0, 4'b0100, 1, 8'hA3, 1, 2'd2);
        row(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        // requester 1, FIFO full for 5 cycles mid-burst, then BURST_MAX ends it
        row(0, 4'b0010, 32'h1122B133, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        row(0, 4'b0010, 32'h1122B133, 4'b0000, 0, 4'b0010, 1, 8'hB1, 1, 2'd1);
        for (int i = 0; i < 5; i++)
            row(0, 4'b0010, 32'h1122B233, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 2'd1);
        row(0, 4'b0010, 32'h1122B233, 4'b0000, 0, 4'b0010, 1, 8'hB2, 1, 2'd1);
        row(0, 4'b0010, 32'h1122B333, 4'b0000, 0, 4'b0010, 1, 8'hB3, 1, 2'd1);
        row(0, 4'b0010, 32'h1122B433, 4'b0000, 0, 4'b0010, 1, 8'hB4, 1, 2'd1);
        row(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd1);
        // requester 0 owner drops valid while 3 waits; grant held until Last
        row(0, 4'b0001, 32'hD10000C1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd1);
        row(0, 4'b0001, 32'hD10000C1, 4'b0000, 0, 4'b0001, 1, 8'hC1, 1, 2'd0);
        for (int i = 0; i < 3; i++)
            row(0, 4'b1000, 32'hD10000C2, 4'b1000, 0, 4'b0001, 0, 8'h00, 1, 2'd0);
        row(0, 4'b1001, 32'hD10000C2, 4'b0001, 0, 4'b0001, 1, 8'hC2, 1, 2'd0);
        row(0, 4'b1000, 32'hD10000C2, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        row(0, 4'b1000, 32'hD10000C2, 4'b1000, 0, 4'b1000, 1, 8'hD1, 1, 2'd3);
        row(0, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd3);
        // reset during requester 0's second word; requester 0 wins again afterwards
        row(0, 4'b0001, 32'h0000F1E1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd3);
        row(0, 4'b0001, 32'h0000F1E1, 4'b0000, 0, 4'b0001, 1, 8'hE1, 1, 2'd0);
        row(1, 4'b0001, 32'h0000F1E2, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd0);
        row(0, 4'b0011, 32'h0000F1E2, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        row(0, 4'b0011, 32'h0000F1E2, 4'b0000, 0, 4'b0001, 1, 8'hE2, 1, 2'd0);

        foreach (tbl[n]) begin
            @(negedge clock);
            reset = tbl[n].rst; requestValid = tbl[n].v; requestData = tbl[n].d;
            requestLast = tbl[n].l; fifoFull = tbl[n].f;
            #1;
            checks++;
            if (requestReady !== tbl[n].rdy || fifoWriteEnable !== tbl[n].we ||
                grantActive !== tbl[n].ga || grantIndex !== tbl[n].gi ||
                (tbl[n].we && fifoWriteData !== tbl[n].wd)) begin
                errors++;
                $display("FAIL vec%0d: got rdy=%b we=%b wd=%h ga=%b gi=%0d, want rdy=%b we=%b wd=%h ga=%b gi=%0d",
                         n, requestReady, fifoWriteEnable, fifoWriteData, grantActive, grantIndex,
                         tbl[n].rdy, tbl[n].we, tbl[n].wd, tbl[n].ga, tbl[n].gi);
            end
        end

        // all four requesting: grants 0,1,2,3,0, four writes each, one IDLE gap
        do_reset();
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clock);
            requestValid = 4'b1111; requestData = 32'h44332211; requestLast = '0; fifoFull = 1'b0;
            #1;
            checks++;
            if ((c % 5) == 0) begin
                if (grantActive !== 1'b0 || fifoWriteEnable !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle c%0d: got ga=%b we=%b, want ga=0 we=0", c, grantActive, fifoWriteEnable);
                end
            end else begin
                if (grantActive !== 1'b1 || fifoWriteEnable !== 1'b1 || grantIndex !== 2'((c / 5) % 4) ||
                    fifoWriteData !== 8'(8'h11 * (((c / 5) % 4) + 1))) begin
                    errors++;
                    $display("FAIL rr_burst c%0d: got ga=%b we=%b gi=%0d wd=%h, want ga=1 we=1 gi=%0d wd=%h",
                             c, grantActive, fifoWriteEnable, grantIndex, fifoWriteData,
                             (c / 5) % 4, 8'(8'h11 * (((c / 5) % 4) + 1)));
                end
            end
        end

        // random valid/last/full: per-requester order, no write when full, burst cap
        do_reset();
        for (int i = 0; i < 4; i++) seq[i] = '0;
        endExp = 1'b0; bw = 0; writes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                requestValid[i] = ($urandom_range(3) != 0);
                requestLast[i]  = ($urandom_range(3) == 0);
                requestData[i*8 +: 8] = {2'(i), seq[i]};
            end
            fifoFull = ($urandom_range(3) == 0);
            #1;
            if (endExp) begin
                checks++;
                if (grantActive !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_end cyc%0d: got ga=%b, want ga=0", cyc, grantActive);
                end
            end
            endExp = 1'b0;
            if (!grantActive) bw = 0;
            if (grantActive && ((requestReady & ~(4'b0001 << grantIndex)) != 4'b0000)) begin
                checks++; errors++;
                $display("FAIL rand_ready cyc%0d: got rdy=%b, want only bit %0d", cyc, requestReady, grantIndex);
            end
            if (fifoWriteEnable) begin
                writes++; bw++;
                expWord = {grantIndex, seq[grantIndex]};
                checks++;
                if (fifoFull) begin
                    errors++;
                    $display("FAIL rand_full cyc%0d: got we=1, want we=0 while full", cyc);
                end
                checks++;
                if (fifoWriteData !== expWord) begin
                    errors++;
                    $display("FAIL rand_data cyc%0d: got wd=%h, want wd=%h", cyc, fifoWriteData, expWord);
                end
                checks++;
                if (bw > BM) begin
                    errors++;
                    $display("FAIL rand_burst cyc%0d: got %0d words, want <= %0d", cyc, bw, BM);
                end
                if (requestLast[grantIndex] || bw == BM) endExp = 1'b1;
            end
            for (int i = 0; i < 4; i++)
                if (requestValid[i] && requestReady[i]) seq[i] = seq[i] + 1'b1;
        end
        checks++;
        if (writes < 300) begin
            errors++;
            $display("FAIL rand_progress: got %0d writes, want >= 300", writes);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
